comparador_serial_izqader: RTL and testbench

COMPARADOR_SERIAL_IZQADER -- requirements
Module: comparador_serial_izqader

---
 rtl/comparador_serial_izqader.sv | 100 ++++++++++
 tb/tb_comparador_serial_izqader.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/comparador_serial_izqader.sv
// MSB-first serial magnitude comparator of two N-bit words fed one bit pair per valid cycle.
// Result flags and a one-cycle done pulse appear the cycle after the N-th pair is consumed.
module comparador_serial_izqader #(
  parameter int N = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic bit_valid,
  input  logic A,
  input  logic B,
  output logic ready,
  output logic busy,
  output logic done,
  output logic A_mayor,
  output logic A_menor,
  output logic iguales
);

  typedef enum logic [1:0] {IDLE = 2'd0, COMPARE = 2'd1, DONE = 2'd2} state_t;

  state_t     r_state;
  state_t     w_next;
  logic [4:0] r_cnt;
  logic       r_decided;
  logic       r_gt;
  logic       r_done;
  logic       r_mayor;
  logic       r_menor;
  logic       r_iguales;

  logic       w_take;
  logic       w_last;
  logic       w_dec;
  logic       w_gt;

  assign w_take = (r_state == COMPARE) && bit_valid;
  assign w_last = (r_cnt == 5'(N - 1));
  // The pair being consumed is folded in here so an LSB-only difference still counts.
  assign w_dec  = r_decided | (A ^ B);
  assign w_gt   = r_decided ? r_gt : A;

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start) w_next = COMPARE;
      COMPARE: if (w_take && w_last) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    ready = (r_state == IDLE);
    busy  = (r_state == COMPARE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt     <= 5'd0;
      r_decided <= 1'b0;
      r_gt      <= 1'b0;
      r_done    <= 1'b0;
      r_mayor   <= 1'b0;
      r_menor   <= 1'b0;
      r_iguales <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (r_state == IDLE && start) begin
        r_cnt     <= 5'd0;
        r_decided <= 1'b0;
        r_gt      <= 1'b0;
        r_mayor   <= 1'b0;
        r_menor   <= 1'b0;
        r_iguales <= 1'b0;
      end else if (w_take) begin
        r_cnt     <= r_cnt + 5'd1;
        r_decided <= w_dec;
        r_gt      <= w_gt;
        if (w_last) begin
          r_done    <= 1'b1;
          r_mayor   <= w_dec & w_gt;
          r_menor   <= w_dec & ~w_gt;
          r_iguales <= ~w_dec;
        end
      end
    end
  end

  assign done    = r_done;
  assign A_mayor = r_mayor;
  assign A_menor = r_menor;
  assign iguales = r_iguales;

endmodule

// File: tb/tb_comparador_serial_izqader.sv
// Scoreboard bench: stimulus queues expected flags and done cycle, a monitor checks each done pulse.
module tb_comparador_serial_izqader;
  localparam int N = 4;

  logic clk = 1'b0;
  logic reset, start, bit_valid, A, B;
  logic ready, busy, done, A_mayor, A_menor, iguales;

  typedef struct {
    logic [2:0] flags;
    int         cyc;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  comparador_serial_izqader #(.N(N)) dut (
    .clk(clk), .reset(reset), .start(start), .bit_valid(bit_valid),
    .A(A), .B(B), .ready(ready), .busy(busy), .done(done),
    .A_mayor(A_mayor), .A_menor(A_menor), .iguales(iguales)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: plain unsigned comparison of the whole words.
  function automatic logic [2:0] ref_flags(input int a, input int b);
    if (a > b)      return 3'b100;
    else if (a < b) return 3'b010;
    else            return 3'b001;
  endfunction

  always @(negedge clk) begin
    if (!reset && done) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("flags", int'({A_mayor, A_menor, iguales}), int'(e.flags));
        check("done_cycle", cyc, e.cyc);
      end
    end
  end

  // stall_at: bit index before which bit_valid drops for stall_len cycles (-1 = never).
  task automatic run_word(input int a, input int b, input int stall_at, input int stall_len,
                          input bit bv_with_start, input bit start_noise);
    start = 1'b1;
    bit_valid = bv_with_start;
    A = 1'b1;
    B = 1'b0;
    tick();
    start = 1'b0;
    check("busy_after_start", int'(busy), 1);
    check("ready_after_start", int'(ready), 0);
    for (int i = N - 1; i >= 0; i--) begin
      if (i == stall_at) begin
        for (int s = 0; s < stall_len; s++) begin
          bit_valid = 1'b0;
          A = $urandom_range(0, 1);
          B = $urandom_range(0, 1);
          start = start_noise;
          tick();
        end
        start = 1'b0;
      end
      bit_valid = 1'b1;
      A = a[i];
      B = b[i];
      start = start_noise;
      if (i == 0) exp_q.push_back('{ref_flags(a, b), cyc + 1});
      tick();
    end
    bit_valid = 1'b0;
    start = 1'b0;
    tick();
    check("ready_after_done", int'(ready), 1);
    check("one_hot_held", int'(A_mayor) + int'(A_menor) + int'(iguales), 1);
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    bit_valid = 1'b0;
    A = 1'b0;
    B = 1'b0;
    tick();
    tick();
    check("rst_ready", int'(ready), 1);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_flags", int'({A_mayor, A_menor, iguales}), 0);
    reset = 1'b0;
    tick();

    run_word(4'b1010, 4'b1001, -1, 0, 1'b0, 1'b0);
    run_word(4'b0111, 4'b1000, -1, 0, 1'b0, 1'b0);
    run_word(4'b0110, 4'b0110, -1, 0, 1'b0, 1'b0);
    run_word(4'b0110, 4'b0111, -1, 0, 1'b0, 1'b0);
    run_word(4'b1100, 4'b1010, 1, 2, 1'b0, 1'b1);
    run_word(4'b0000, 4'b0000, -1, 0, 1'b1, 1'b0);

    // Abort after two consumed bits; any done from this word is unexpected.
    start = 1'b1;
    tick();
    start = 1'b0;
    bit_valid = 1'b1;
    A = 1'b1; B = 1'b0; tick();
    A = 1'b0; B = 1'b1; tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    bit_valid = 1'b0;
    check("abort_ready", int'(ready), 1);
    check("abort_busy", int'(busy), 0);
    check("abort_done", int'(done), 0);
    check("abort_flags", int'({A_mayor, A_menor, iguales}), 0);
    tick();
    check("abort_no_done", int'(done), 0);
    run_word(4'b0001, 4'b0000, -1, 0, 1'b0, 1'b0);

    for (int k = 0; k < 40; k++) begin
      int a, b;
      a = $urandom_range(0, 15);
      b = ($urandom_range(0, 3) == 0) ? a : $urandom_range(0, 15);
      run_word(a, b, $urandom_range(0, 5) - 2, $urandom_range(1, 3),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 2) == 0) tick();
    end

    for (int w = 0; w < 10 && exp_q.size() != 0; w++) tick();
    check("scoreboard_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end
endmodule
